// File: rtl/mesh_sort_ctrl_pkg.sv
// Shared types and width helpers for the sorting-mesh sequencer.
// Optional MESH_SORT_CTRL_PERF_EN adds run/abort counters to the top.
package mesh_ctrl_pkg;

  localparam int N_DEF           = 256;
  localparam int SIDE_DEF        = 16;
  localparam int SORT_CYCLES_DEF = 112;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT,
    WRITE,
    DONE
  } state_t;

  function automatic int step_w(int side);
    return (side > 1) ? $clog2(side) : 1;
  endfunction

  function automatic int phase_w(int sc, int side);
    return $clog2(sc / side) + 1;
  endfunction

  function automatic int cnt_w(int sc);
    return (sc > 1) ? $clog2(sc) : 1;
  endfunction

endpackage

// File: rtl/mesh_sort_ctrl_if.sv
// Start handshake and mesh control strobes of the sort sequencer.
// Optional MESH_SORT_CTRL_PERF_EN does not change this bundle.
interface mesh_sort_ctrl_if
  import mesh_ctrl_pkg::*;
#(
  parameter int SIDE        = SIDE_DEF,
  parameter int SORT_CYCLES = SORT_CYCLES_DEF
);

  localparam int SW = step_w(SIDE);
  localparam int PW = phase_w(SORT_CYCLES, SIDE);

  logic          start_valid;
  logic          start_ready;
  logic          abort;
  logic          load_en;
  logic          sort_en;
  logic          row_phase;
  logic          odd_step;
  logic [SW-1:0] step_idx;
  logic [PW-1:0] phase_idx;
  logic          write_en;
  logic          busy;
  logic          done;

  modport master (
    output start_valid, abort,
    input  start_ready, load_en, sort_en,
    input  row_phase, odd_step,
    input  step_idx, phase_idx,
    input  write_en, busy, done
  );

  modport slave (
    input  start_valid, abort,
    output start_ready, load_en, sort_en,
    output row_phase, odd_step,
    output step_idx, phase_idx,
    output write_en, busy, done
  );

endinterface

// File: rtl/mesh_sort_ctrl_counter.sv
// Sort-cycle counter: splits the count into step/phase fields.
// Optional MESH_SORT_CTRL_PERF_EN does not affect this module.
module mesh_step_counter
  import mesh_ctrl_pkg::*;
#(
  parameter int SIDE        = SIDE_DEF,
  parameter int SORT_CYCLES = SORT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [step_w(SIDE)-1:0] step_idx,
  output logic [phase_w(SORT_CYCLES, SIDE)-1:0] phase_idx,
  output logic row_phase,
  output logic odd_step,
  output logic last
);

  localparam int CW = cnt_w(SORT_CYCLES);
  localparam int SW = step_w(SIDE);
  localparam int PW = phase_w(SORT_CYCLES, SIDE);

  logic [CW-1:0] cnt;
  int            c;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign c = int'(cnt);

  // Fields read as zero whenever the mesh is not sorting.
  assign step_idx  = en ? SW'(c % SIDE) : '0;
  assign phase_idx = en ? PW'(c / SIDE) : '0;
  assign row_phase = en & ~phase_idx[0];
  assign odd_step  = step_idx[0];
  assign last      = en && (c == SORT_CYCLES - 1);

endmodule

// File: rtl/mesh_sort_ctrl.sv
// Load / sort / write-back sequencer for the 16x16 sorting mesh.
// Define MESH_SORT_CTRL_PERF_EN to add run_count and abort_count.
module mesh_sort_ctrl
  import mesh_ctrl_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int SIDE        = SIDE_DEF,
  parameter int SORT_CYCLES = SORT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  mesh_sort_ctrl_if.slave bus
`ifdef MESH_SORT_CTRL_PERF_EN
  ,
  output logic [15:0] run_count,
  output logic [15:0] abort_count
`endif
);

  if (N != SIDE * SIDE || SORT_CYCLES <= 0 ||
      SORT_CYCLES % SIDE != 0) begin : g_bad_cfg
    $error("mesh_sort_ctrl: bad N/SIDE/SORT_CYCLES");
  end

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   in_sort;
  logic   clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start_valid && !bus.abort) state_nxt = LOAD;
      LOAD:  state_nxt = SORT;
      SORT:  if (last) state_nxt = WRITE;
      WRITE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) state_nxt = IDLE;
  end

  always_comb begin
    bus.start_ready = (state == IDLE) & ~rst & ~bus.abort;
    bus.busy        = (state != IDLE);
    bus.load_en     = 1'b0;
    bus.sort_en     = 1'b0;
    bus.write_en    = 1'b0;
    bus.done        = 1'b0;
    unique case (1'b1)
      state == LOAD:  bus.load_en  = 1'b1;
      state == SORT:  bus.sort_en  = 1'b1;
      state == WRITE: bus.write_en = 1'b1;
      state == DONE:  bus.done     = 1'b1;
      default: ;
    endcase
  end

  assign in_sort = (state == SORT);
  assign clr     = (state_nxt != SORT);

  mesh_step_counter #(
    .SIDE        (SIDE),
    .SORT_CYCLES (SORT_CYCLES)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (in_sort),
    .step_idx  (bus.step_idx),
    .phase_idx (bus.phase_idx),
    .row_phase (bus.row_phase),
    .odd_step  (bus.odd_step),
    .last      (last)
  );

`ifdef MESH_SORT_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_count   <= '0;
      abort_count <= '0;
    end else begin
      if (state == DONE && run_count != 16'hFFFF)
        run_count <= run_count + 16'd1;
      if (bus.abort && state != IDLE && abort_count != 16'hFFFF)
        abort_count <= abort_count + 16'd1;
    end
  end
`endif

endmodule
